// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port register file.
package reg_file_pkg;

    typedef enum logic {
        INIT,
        RUN
    } rf_state_t;

    localparam int unsigned RF_DW  = 8;
    localparam int unsigned RF_PW  = 4;
    localparam int unsigned RF_NRD = 2;

    typedef logic [RF_DW-1:0] rf_word_t;

endpackage

// File: rtl/reg_file_init_seq.sv
// Post-reset zero-fill sequencer: sweeps every entry once, then raises ready.
module reg_file_init_seq
    import reg_file_pkg::*;
#(
    parameter int unsigned PW = RF_PW
) (
    input  logic          clk,
    input  logic          reset,
    output logic          init_we,
    output logic [PW-1:0] init_addr,
    output logic          ready
);

    localparam int unsigned DEPTH = 2 ** PW;

    rf_state_t     state_q, state_d;
    logic [PW:0]   ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        init_we   = 1'b0;
        init_addr = ptr_q[PW-1:0];
        ready     = 1'b0;
        case (state_q)
            INIT: begin
                init_we = 1'b1;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == (PW+1)'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: one write port, NRD combinational read ports,
// a fixed tap register, optional write-through bypass and a zero-fill after reset.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DW     = RF_DW,
    parameter int unsigned PW     = RF_PW,
    parameter int unsigned NRD    = RF_NRD,
    parameter int unsigned TAP    = (2 ** PW) - 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [PW-1:0]           wr_addr,
    input  logic [DW-1:0]           dat_in,
    input  logic [NRD-1:0][PW-1:0]  rd_addr,
    output logic [NRD-1:0][DW-1:0]  dat_out,
    output logic [DW-1:0]           tap_out,
    output logic                    ready
);

    localparam int unsigned   DEPTH = 2 ** PW;
    localparam logic [PW-1:0] TAP_A = PW'(TAP);

    logic          init_we;
    logic [PW-1:0] init_addr;
    logic          we;
    logic [PW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          byp_ok;
    logic [DW-1:0] core [DEPTH];

    reg_file_init_seq #(
        .PW (PW)
    ) u_init (
        .clk       (clk),
        .reset     (reset),
        .init_we   (init_we),
        .init_addr (init_addr),
        .ready     (ready)
    );

    // Single write port: the sweep owns it until ready, the user afterwards.
    always_comb begin
        we    = init_we;
        waddr = init_addr;
        wdata = '0;
        if (ready) begin
            we    = wr_en;
            waddr = wr_addr;
            wdata = dat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            core[waddr] <= wdata;
        end
    end

    assign byp_ok = (BYPASS != 0) && wr_en;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign dat_out[i] = !ready ? '0 :
                            (byp_ok && (rd_addr[i] == wr_addr)) ? dat_in :
                            core[rd_addr[i]];
    end

    assign tap_out = !ready ? '0 :
                     (byp_ok && (wr_addr == TAP_A)) ? dat_in :
                     core[TAP_A];

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: default (bypass), no-bypass and 16x3-port/8-entry instances.
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default and BYPASS=0 instances share stimulus
    logic            reset, wr_en;
    logic [3:0]      wr_addr;
    logic [7:0]      dat_in;
    logic [1:0][3:0] rd_addr;
    logic [1:0][7:0] dat_out, nb_dat_out;
    logic [7:0]      tap_out, nb_tap_out;
    logic            ready, nb_ready;

    logic             g_reset, g_wr_en;
    logic [2:0]       g_wr_addr;
    logic [15:0]      g_dat_in;
    logic [2:0][2:0]  g_rd_addr;
    logic [2:0][15:0] g_dat_out;
    logic [15:0]      g_tap_out;
    logic             g_ready;

    reg_file_mp dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addr(rd_addr), .dat_out(dat_out), .tap_out(tap_out), .ready(ready)
    );

    reg_file_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
        .rd_addr(rd_addr), .dat_out(nb_dat_out), .tap_out(nb_tap_out), .ready(nb_ready)
    );

    reg_file_mp #(.DW(16), .PW(3), .NRD(3), .TAP(0)) dut_g (
        .clk(clk), .reset(g_reset), .wr_en(g_wr_en), .wr_addr(g_wr_addr), .dat_in(g_dat_in),
        .rd_addr(g_rd_addr), .dat_out(g_dat_out), .tap_out(g_tap_out), .ready(g_ready)
    );

    typedef enum int {S_RDY, S_D0, S_D1, S_TAP, S_NBRDY, S_NB0, S_NBTAP,
                      S_GRDY, S_GD0, S_GD1, S_GD2, S_GTAP} sig_e;

    typedef struct {
        sig_e        sel;
        logic [15:0] exp;
        string       name;
    } sb_t;

    sb_t sbq[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    function automatic logic [15:0] actual(sig_e s);
        case (s)
            S_RDY:   return {15'd0, ready};
            S_D0:    return {8'd0, dat_out[0]};
            S_D1:    return {8'd0, dat_out[1]};
            S_TAP:   return {8'd0, tap_out};
            S_NBRDY: return {15'd0, nb_ready};
            S_NB0:   return {8'd0, nb_dat_out[0]};
            S_NBTAP: return {8'd0, nb_tap_out};
            S_GRDY:  return {15'd0, g_ready};
            S_GD0:   return g_dat_out[0];
            S_GD1:   return g_dat_out[1];
            S_GD2:   return g_dat_out[2];
            S_GTAP:  return g_tap_out;
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic push(input sig_e s, input logic [15:0] e, input string n);
        sb_t t;
        t.sel = s; t.exp = e; t.name = n;
        sbq.push_back(t);
    endtask

    // Sample on the falling edge, drain the scoreboard, then advance past the next rising edge.
    task automatic tick();
        sb_t t;
        logic [15:0] a;
        @(negedge clk);
        while (sbq.size() > 0) begin
            t = sbq.pop_front();
            a = actual(t.sel);
            n_tests++;
            if (a !== t.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", t.name, a, t.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Watch a sweep of `n` entries: ready low for n samples, outputs forced low.
    task automatic sweep_check(input int n, input string tag);
        for (int k = 0; k <= n; k++) begin
            push(S_RDY, 16'(k >= n), $sformatf("%s_ready_k%0d", tag, k));
            push(S_D0, 16'h0, $sformatf("%s_d0_k%0d", tag, k));
            push(S_D1, 16'h0, $sformatf("%s_d1_k%0d", tag, k));
            push(S_TAP, 16'h0, $sformatf("%s_tap_k%0d", tag, k));
            push(S_NBRDY, 16'(k >= n), $sformatf("%s_nbready_k%0d", tag, k));
            if (k == 5) begin
                wr_en = 1'b1; wr_addr = 4'd3; dat_in = 8'hAA;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
    endtask

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [3:0] r0, r1;
        logic [7:0] e0, e1, etap, enb0;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 4'd7,  8'h5C, 4'd7,  4'd7,  8'h5C, 8'h5C, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 4'd0,  8'h00, 4'd7,  4'd7,  8'h5C, 8'h5C, 8'h00, 8'h5C};
        vecs[2] = '{1'b1, 4'd15, 8'h81, 4'd15, 4'd0,  8'h81, 8'h00, 8'h81, 8'h00};
        vecs[3] = '{1'b0, 4'd0,  8'h00, 4'd15, 4'd7,  8'h81, 8'h5C, 8'h81, 8'h81};
        vecs[4] = '{1'b1, 4'd4,  8'h3E, 4'd4,  4'd7,  8'h3E, 8'h5C, 8'h81, 8'h00};
        vecs[5] = '{1'b0, 4'd0,  8'h00, 4'd4,  4'd4,  8'h3E, 8'h3E, 8'h81, 8'h3E};
        vecs[6] = '{1'b1, 4'd2,  8'h11, 4'd2,  4'd15, 8'h11, 8'h81, 8'h81, 8'h00};
        vecs[7] = '{1'b0, 4'd0,  8'h00, 4'd2,  4'd2,  8'h11, 8'h11, 8'h81, 8'h11};

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; dat_in = '0; rd_addr = '0;
        g_reset = 1'b1; g_wr_en = 1'b0; g_wr_addr = '0; g_dat_in = '0; g_rd_addr = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sweep after reset, with a write attempt in the middle of it
        rd_addr[0] = 4'd3; rd_addr[1] = 4'd0;
        sweep_check(16, "init");

        for (int a = 0; a < 16; a++) begin
            rd_addr[0] = 4'(a); rd_addr[1] = 4'(15 - a);
            push(S_D0, 16'h0, $sformatf("zero_p0_a%0d", a));
            push(S_D1, 16'h0, $sformatf("zero_p1_a%0d", a));
            push(S_NB0, 16'h0, $sformatf("nb_zero_a%0d", a));
            tick();
        end

        for (int i = 0; i < 8; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; dat_in = vecs[i].wd;
            rd_addr[0] = vecs[i].r0; rd_addr[1] = vecs[i].r1;
            push(S_RDY, 16'h1, $sformatf("vec%0d_ready", i));
            push(S_D0, {8'h0, vecs[i].e0}, $sformatf("vec%0d_d0", i));
            push(S_D1, {8'h0, vecs[i].e1}, $sformatf("vec%0d_d1", i));
            push(S_TAP, {8'h0, vecs[i].etap}, $sformatf("vec%0d_tap", i));
            push(S_NB0, {8'h0, vecs[i].enb0}, $sformatf("vec%0d_nb_d0", i));
            tick();
        end
        wr_en = 1'b0;
        push(S_NBTAP, 16'h0081, "nb_tap_after_write");
        tick();

        // Reset in RUN: contents must be re-zeroed by a fresh sweep
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_addr[0] = 4'd2; rd_addr[1] = 4'd15;
        sweep_check(16, "rerun");

        // 16-bit, 8-entry, 3-port instance with the tap at entry 0
        g_reset = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            push(S_GRDY, 16'(k >= 8), $sformatf("g_ready_k%0d", k));
            push(S_GD0, 16'h0, $sformatf("g_d0_k%0d", k));
            push(S_GTAP, 16'h0, $sformatf("g_tap_k%0d", k));
            tick();
        end
        g_wr_en = 1'b1; g_wr_addr = 3'd0; g_dat_in = 16'hBEEF; g_rd_addr = '0;
        push(S_GD0, 16'hBEEF, "g_byp_d0");
        push(S_GD1, 16'hBEEF, "g_byp_d1");
        push(S_GD2, 16'hBEEF, "g_byp_d2");
        push(S_GTAP, 16'hBEEF, "g_byp_tap");
        tick();
        g_wr_addr = 3'd5; g_dat_in = 16'h1234;
        g_rd_addr[0] = 3'd0; g_rd_addr[1] = 3'd1; g_rd_addr[2] = 3'd0;
        push(S_GD0, 16'hBEEF, "g_rd_d0");
        push(S_GD1, 16'h0000, "g_rd_d1");
        push(S_GD2, 16'hBEEF, "g_rd_d2");
        push(S_GTAP, 16'hBEEF, "g_rd_tap");
        tick();
        g_wr_en = 1'b0;
        g_rd_addr[0] = 3'd5; g_rd_addr[1] = 3'd0; g_rd_addr[2] = 3'd7;
        push(S_GD0, 16'h1234, "g_wr5_d0");
        push(S_GD1, 16'hBEEF, "g_wr5_d1");
        push(S_GD2, 16'h0000, "g_wr5_d2");
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
